demux_router: RTL and testbench
===============================

# demux_router

Two-way demultiplexing router: the inverse of the team's 2:1 select multiplexer. It accepts a stream of WIDTH-bit words with a per-word select bit and delivers each word, in order, to one of two output channels. Each output channel has a DEPTH-entry buffer and a valid/ready handshake. A stalled channel back-pressures the input only for words addressed to it. Per-channel delivery counters feed status/debug logic.

## Interface
- WIDTH, 16, data word width (matches the 16-bit bus paths)
- DEPTH, 2, entries per channel buffer; power of two, ≥ 2
- CNT_W, 8, width of each delivery counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; synchronous, active-low
- in_data  in  WIDTH  input word
- in_sel  in  1  destination: 0 → channel 0, 1 → channel 1
- in_valid  in  1  input word present
- in_ready  out  1  router accepts the word this cycle
- out0_data / out1_data  out  WIDTH  head word of channel buffer
- out0_valid / out1_valid  out  1  channel buffer non-empty
- out0_ready / out1_ready  in  1  downstream takes head word
- cnt0 / cnt1  out  CNT_W  words delivered on each channel, modulo 2^CNT_W

## Operation
- Input handshake: word accepted when in_valid && in_ready at a rising edge.
- in_ready = rst_n && !full[in_sel]. This is combinational on in_sel and the registered full flags only. It never depends on out*_ready, so there is no pass-through when full.
- Accepted word is written to the buffer of channel in_sel at the write pointer. That pointer then advances modulo DEPTH.
- Output handshake: outX_valid && outX_ready pops the head, advances the read pointer modulo DEPTH, and increments cntX.
- outX_data = storage[rd_ptr] of channel X. When outX_valid = 0 the value is the stale entry; the bench must not check it.
- Order is preserved within a channel. There is no ordering relation between channels.
- Each channel tracks occupancy as a count of 0..DEPTH. full = (count == DEPTH); empty = (count == 0).
- Push and pop on the same channel in the same cycle are legal whenever not full. Count is unchanged and both pointers advance.
- Pop on a full channel frees one slot. in_ready for that channel rises in the next cycle, not the same one.
- Counters wrap from 2^CNT_W−1 to 0 without a flag.
- in_valid = 0: no state change apart from pops.
- Reset (rst_n low at an edge, including mid-transfer):
  - All pointers, occupancy counts, cnt0/cnt1 and storage are cleared to 0.
  - Buffered words are discarded.
  - in_ready is 0 for the whole time rst_n is low.
- Outputs after reset: in_ready = 1 (once rst_n is high), out0_valid = out1_valid = 0, out0_data = out1_data = 0, cnt0 = cnt1 = 0.

## Timing
- Latency: a word accepted at edge N gives outX_valid = 1 and that word on outX_data after edge N, i.e. in cycle N+1.
- Throughput: one word per cycle sustained per channel when downstream holds outX_ready = 1.
- Input throughput is limited only by the full state of the addressed channel.
- outX_valid, full and cntX are registered. in_ready is combinational from in_sel, the full flags and rst_n.
- The first edge with rst_n high may accept a word.

## Structure
- Shared package demux_pkg:
  - channel select constants CH0 = 1'b0, CH1 = 1'b1
  - default WIDTH/DEPTH/CNT_W values
  - ptr width localparam $clog2(DEPTH)
- Sub-module chan_fifo: per-channel storage, pointers, occupancy, full/empty and delivery counter. Instantiated twice.
- demux_router top: write-enable decode from in_sel and the in_ready mux, using the two chan_fifo instances.

## Test plan
- Reset, then send 16'hA5A5 sel=0 with out0_ready=1:
  - out0_valid = 1 with 16'hA5A5 in the next cycle, cnt0 = 1
  - out1_valid stays 0
- Alternate sel 0/1 with data 1..8 and both readies = 1:
  - ch0 gets 1,3,5,7 and ch1 gets 2,4,6,8, each one cycle after acceptance
  - cnt0 = cnt1 = 4
- Hold out0_ready = 0 and push 3 words to sel=0 (DEPTH=2):
  - first two accepted; in_ready = 0 on the third
  - sel=1 words are still accepted during the stall
  - raise out0_ready: third word accepted the cycle after the first pop; order preserved
- Full channel with simultaneous pop and in_valid: no same-cycle accept; accept occurs one cycle later.
- 256 deliveries on ch1 with CNT_W=8 → cnt1 wraps to 0.
- Fill both channels, assert rst_n = 0 for one edge:
  - out*_valid = 0, cnt* = 0 and in_ready = 0 during reset
  - in_ready = 1 after reset; old words never appear.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the two-way demultiplexing router: channel select codes
// and default geometry.
package demux_pkg;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 2;
    localparam int DEFAULT_CNT_W = 8;

    localparam int PTR_W = $clog2(DEFAULT_DEPTH);

endpackage

// File: rtl/chan_fifo.sv
// One output channel of the router: DEPTH-entry buffer with pointers, occupancy
// tracking, valid/ready output handshake and a wrapping delivery counter.
module chan_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             full,
    output logic [CNT_W-1:0] cnt
);

    localparam int PW    = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [OCC_W-1:0] occ_reg;
    logic [OCC_W-1:0] occ_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             pop;

    assign valid = (occ_reg != '0);
    assign full  = (occ_reg == OCC_W'(DEPTH));
    assign pop   = valid && pop_ready;
    assign data  = mem_reg[rd_ptr_reg];
    assign cnt   = cnt_reg;

    // push is only ever raised by the top when this channel is not full
    always_comb begin
        occ_next = occ_reg;
        if (push && !pop) begin
            occ_next = occ_reg + 1'b1;
        end else if (!push && pop) begin
            occ_next = occ_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                cnt_reg    <= cnt_reg + 1'b1;
            end
            occ_reg <= occ_next;
        end
    end

endmodule

// File: rtl/demux_router.sv
// Two-way demultiplexing router: steers each input word to channel in_sel,
// back-pressuring only when the addressed channel's buffer is full.
module demux_router
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic full0;
    logic full1;
    logic accept;
    logic push0;
    logic push1;

    // Registered full flags only: a same-cycle pop never opens the input.
    assign in_ready = rst_n && ((in_sel == CH1) ? !full1 : !full0);
    assign accept   = in_valid && in_ready;
    assign push0    = accept && (in_sel == CH0);
    assign push1    = accept && (in_sel == CH1);

    chan_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_chan0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .push_data (in_data),
        .pop_ready (out0_ready),
        .data      (out0_data),
        .valid     (out0_valid),
        .full      (full0),
        .cnt       (cnt0)
    );

    chan_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_chan1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (in_data),
        .pop_ready (out1_ready),
        .data      (out1_data),
        .valid     (out1_valid),
        .full      (full1),
        .cnt       (cnt1)
    );

endmodule

// File: tb/tb_demux_router.sv
// Directed bench for demux_router: inputs change and outputs are checked on the
// falling edge, so every check sees the state left by the preceding rising edge.
module tb_demux_router;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [15:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [7:0]  cnt0;
    logic [7:0]  cnt1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    demux_router dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
        $display("[TB] check %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = '0;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        repeat (3) cyc();
        chk("rst_in_ready_low", 32'(in_ready), 32'd0);

        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out0_valid", 32'(out0_valid), 32'd0);
        chk("post_rst_out1_valid", 32'(out1_valid), 32'd0);
        chk("post_rst_out0_data", 32'(out0_data), 32'd0);
        chk("post_rst_out1_data", 32'(out1_data), 32'd0);
        chk("post_rst_cnt0", 32'(cnt0), 32'd0);
        chk("post_rst_cnt1", 32'(cnt1), 32'd0);

        // Single word on channel 0
        in_data = 16'hA5A5; in_sel = 1'b0; in_valid = 1'b1; out0_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("single_out0_valid", 32'(out0_valid), 32'd1);
        chk("single_out0_data", 32'(out0_data), 32'hA5A5);
        chk("single_out1_valid", 32'(out1_valid), 32'd0);
        cyc();
        chk("single_out0_drained", 32'(out0_valid), 32'd0);
        chk("single_cnt0", 32'(cnt0), 32'd1);

        // Alternating select, both channels draining every cycle
        out1_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 16'(i); in_sel = (i % 2 == 0); in_valid = 1'b1;
            #1;
            chk($sformatf("alt_in_ready_%0d", i), 32'(in_ready), 32'd1);
            cyc();
            if (i % 2 == 1) begin
                chk($sformatf("alt_ch0_valid_%0d", i), 32'(out0_valid), 32'd1);
                chk($sformatf("alt_ch0_data_%0d", i), 32'(out0_data), 32'(i));
                chk($sformatf("alt_ch1_idle_%0d", i), 32'(out1_valid), 32'd0);
            end else begin
                chk($sformatf("alt_ch1_valid_%0d", i), 32'(out1_valid), 32'd1);
                chk($sformatf("alt_ch1_data_%0d", i), 32'(out1_data), 32'(i));
                chk($sformatf("alt_ch0_idle_%0d", i), 32'(out0_valid), 32'd0);
            end
        end
        in_valid = 1'b0;
        cyc();
        chk("alt_cnt0", 32'(cnt0), 32'd5);
        chk("alt_cnt1", 32'(cnt1), 32'd4);

        // Stall channel 0 until full; channel 1 keeps flowing
        out0_ready = 1'b0;
        in_sel = 1'b0; in_data = 16'h0010; in_valid = 1'b1;
        #1;
        chk("stall_accept_1", 32'(in_ready), 32'd1);
        cyc();
        in_data = 16'h0011;
        #1;
        chk("stall_accept_2", 32'(in_ready), 32'd1);
        cyc();
        in_data = 16'h0012;
        #1;
        chk("stall_full_block", 32'(in_ready), 32'd0);
        chk("stall_head", 32'(out0_data), 32'h0010);
        in_sel = 1'b1; in_data = 16'h0020;
        #1;
        chk("stall_ch1_open", 32'(in_ready), 32'd1);
        cyc();
        chk("stall_ch1_valid", 32'(out1_valid), 32'd1);
        chk("stall_ch1_data", 32'(out1_data), 32'h0020);
        // Pop on a full channel with the input waiting: no same-cycle accept
        in_sel = 1'b0; in_data = 16'h0012; out0_ready = 1'b1;
        #1;
        chk("full_pop_no_bypass", 32'(in_ready), 32'd0);
        cyc();
        chk("after_pop_ready", 32'(in_ready), 32'd1);
        chk("after_pop_head", 32'(out0_data), 32'h0011);
        cyc();
        in_valid = 1'b0;
        chk("order_third_valid", 32'(out0_valid), 32'd1);
        chk("order_third_data", 32'(out0_data), 32'h0012);
        cyc();
        chk("stall_drained", 32'(out0_valid), 32'd0);
        chk("stall_cnt0", 32'(cnt0), 32'd8);
        chk("stall_cnt1", 32'(cnt1), 32'd5);

        // Stream channel 1 until its counter wraps (5 + 251 = 256)
        in_sel = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 251; i++) begin
            in_data = 16'(16'h0100 + i);
            cyc();
        end
        in_valid = 1'b0;
        chk("wrap_cnt1_255", 32'(cnt1), 32'd255);
        chk("wrap_last_data", 32'(out1_data), 32'h01FA);
        cyc();
        chk("wrap_cnt1_0", 32'(cnt1), 32'd0);
        chk("wrap_cnt0_untouched", 32'(cnt0), 32'd8);

        // Fill both channels, then reset mid-transfer
        out0_ready = 1'b0; out1_ready = 1'b0; in_valid = 1'b1;
        in_sel = 1'b0; in_data = 16'h00B0; cyc();
        in_data = 16'h00B1; cyc();
        in_sel = 1'b1; in_data = 16'h00C0; cyc();
        in_data = 16'h00C1; cyc();
        chk("fill_ch1_blocked", 32'(in_ready), 32'd0);
        in_sel = 1'b0;
        #1;
        chk("fill_ch0_blocked", 32'(in_ready), 32'd0);
        chk("fill_out0_valid", 32'(out0_valid), 32'd1);
        chk("fill_out1_valid", 32'(out1_valid), 32'd1);

        rst_n = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        #1;
        chk("midrst_in_ready_comb", 32'(in_ready), 32'd0);
        cyc();
        chk("midrst_out0_valid", 32'(out0_valid), 32'd0);
        chk("midrst_out1_valid", 32'(out1_valid), 32'd0);
        chk("midrst_cnt0", 32'(cnt0), 32'd0);
        chk("midrst_cnt1", 32'(cnt1), 32'd0);
        chk("midrst_out0_data", 32'(out0_data), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("rerst_in_ready", 32'(in_ready), 32'd1);
        cyc();
        chk("rerst_no_old_ch0", 32'(out0_valid), 32'd0);
        chk("rerst_no_old_ch1", 32'(out1_valid), 32'd0);
        in_sel = 1'b0; in_data = 16'h00D0; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("rerst_new_valid", 32'(out0_valid), 32'd1);
        chk("rerst_new_data", 32'(out0_data), 32'h00D0);
        cyc();
        chk("rerst_cnt0", 32'(cnt0), 32'd1);
        chk("rerst_cnt1", 32'(cnt1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
